// File: rtl/imem_dmem_arbiter_if.sv
// Bundle of core-side fetch/data ports and SRAM-side ports for imem_dmem_arbiter.
// Perf counter outputs exist only when ARB_PERF_CNT_EN is defined.
interface imem_dmem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              if_req_in;
   logic [ADDR_W-1:0] if_addr_in;
   logic [31:0]       if_data_out;
   logic              if_valid_out;
   logic              dm_req_in;
   logic              dm_wr_in;
   logic [ADDR_W-1:0] dm_addr_in;
   logic [3:0]        dm_wr_mask_in;
   logic [31:0]       dm_wdata_in;
   logic [31:0]       dm_rdata_out;
   logic              dm_valid_out;
   logic              mem_en_out;
   logic              mem_we_out;
   logic [3:0]        mem_mask_out;
   logic [ADDR_W-1:0] mem_addr_out;
   logic [31:0]       mem_wdata_out;
   logic [31:0]       mem_rdata_in;
   logic              busy_out;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]       if_grant_cnt_out;
   logic [31:0]       dm_grant_cnt_out;
   logic [31:0]       conflict_cnt_out;
`endif

   modport slave (
      input  if_req_in, if_addr_in,
      input  dm_req_in, dm_wr_in, dm_addr_in, dm_wr_mask_in, dm_wdata_in,
      input  mem_rdata_in,
      output if_data_out, if_valid_out, dm_rdata_out, dm_valid_out,
      output mem_en_out, mem_we_out, mem_mask_out, mem_addr_out,
      output mem_wdata_out, busy_out
`ifdef ARB_PERF_CNT_EN
      , output if_grant_cnt_out, dm_grant_cnt_out, conflict_cnt_out
`endif
   );

   modport master (
      output if_req_in, if_addr_in,
      output dm_req_in, dm_wr_in, dm_addr_in, dm_wr_mask_in, dm_wdata_in,
      output mem_rdata_in,
      input  if_data_out, if_valid_out, dm_rdata_out, dm_valid_out,
      input  mem_en_out, mem_we_out, mem_mask_out, mem_addr_out,
      input  mem_wdata_out, busy_out
`ifdef ARB_PERF_CNT_EN
      , input if_grant_cnt_out, dm_grant_cnt_out, conflict_cnt_out
`endif
   );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Fetch/data arbiter onto one single-port SRAM: IDLE->ISSUE->WAIT->RESP.
// Optional grant/conflict counters enabled by defining ARB_PERF_CNT_EN.
module imem_dmem_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int MEM_LAT         = 1,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic clk_in,
   input  logic rst_in,
   imem_dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [2:0] LAT  = 3'(MEM_LAT);
   localparam logic [3:0] MAXS = 4'(MAX_DATA_STREAK);

   state_t            r_state;
   logic              r_owner_dm;
   logic              r_is_wr;
   logic [2:0]        r_lat;
   logic [3:0]        r_streak;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [3:0]        r_mem_mask;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [31:0]       r_if_data;
   logic              r_if_valid;
   logic [31:0]       r_dm_rdata;
   logic              r_dm_valid;

   logic              w_grant_dm;
   logic              w_grant_if;
   logic              w_conflict;
   logic [ADDR_W-1:0] w_grant_addr;

   // DM wins a conflict until it has used up its streak allowance.
   assign w_conflict   = bus.if_req_in & bus.dm_req_in;
   assign w_grant_dm   = bus.dm_req_in & ~(bus.if_req_in & (r_streak == MAXS));
   assign w_grant_if   = bus.if_req_in & ~w_grant_dm;
   assign w_grant_addr = w_grant_dm ? bus.dm_addr_in : bus.if_addr_in;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state     <= S_IDLE;
         r_owner_dm  <= 1'b0;
         r_is_wr     <= 1'b0;
         r_lat       <= '0;
         r_streak    <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_mask  <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_data   <= '0;
         r_if_valid  <= 1'b0;
         r_dm_rdata  <= '0;
         r_dm_valid  <= 1'b0;
      end else begin
         r_if_valid <= 1'b0;
         r_dm_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_grant_dm) begin
                  r_owner_dm  <= 1'b1;
                  r_is_wr     <= bus.dm_wr_in;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= bus.dm_wr_in;
                  r_mem_mask  <= bus.dm_wr_mask_in;
                  r_mem_addr  <= w_grant_addr;
                  r_mem_wdata <= bus.dm_wdata_in;
                  r_streak    <= (r_streak == MAXS) ? MAXS : r_streak + 4'd1;
                  r_state     <= S_ISSUE;
               end else if (w_grant_if) begin
                  r_owner_dm  <= 1'b0;
                  r_is_wr     <= 1'b0;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_mask  <= '0;
                  r_mem_addr  <= w_grant_addr;
                  r_mem_wdata <= '0;
                  r_streak    <= '0;
                  r_state     <= S_ISSUE;
               end else begin
                  r_streak <= '0;
               end
            end
            S_ISSUE: begin
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
               r_lat    <= 3'd1;
               r_state  <= S_WAIT;
            end
            S_WAIT: begin
               if (r_lat == LAT) begin
                  if (r_owner_dm) begin
                     if (!r_is_wr) r_dm_rdata <= bus.mem_rdata_in;
                     r_dm_valid <= 1'b1;
                  end else begin
                     r_if_data  <= bus.mem_rdata_in;
                     r_if_valid <= 1'b1;
                  end
                  r_state <= S_RESP;
               end else begin
                  r_lat <= r_lat + 3'd1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] r_if_cnt;
   logic [31:0] r_dm_cnt;
   logic [31:0] r_cf_cnt;
   logic        w_idle;

   assign w_idle = (r_state == S_IDLE);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_if_cnt <= '0;
         r_dm_cnt <= '0;
         r_cf_cnt <= '0;
      end else if (w_idle) begin
         if (w_grant_if) r_if_cnt <= r_if_cnt + 32'd1;
         if (w_grant_dm) r_dm_cnt <= r_dm_cnt + 32'd1;
         if (w_conflict) r_cf_cnt <= r_cf_cnt + 32'd1;
      end
   end

   assign bus.if_grant_cnt_out = r_if_cnt;
   assign bus.dm_grant_cnt_out = r_dm_cnt;
   assign bus.conflict_cnt_out = r_cf_cnt;
`else
   logic w_unused;
   assign w_unused = w_conflict;
`endif

   assign bus.mem_en_out    = r_mem_en;
   assign bus.mem_we_out    = r_mem_we;
   assign bus.mem_mask_out  = r_mem_mask;
   assign bus.mem_addr_out  = r_mem_addr;
   assign bus.mem_wdata_out = r_mem_wdata;
   assign bus.if_data_out   = r_if_data;
   assign bus.if_valid_out  = r_if_valid;
   assign bus.dm_rdata_out  = r_dm_rdata;
   assign bus.dm_valid_out  = r_dm_valid;
   assign bus.busy_out      = (r_state != S_IDLE);
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: MEM_LAT=1 instance plus a MEM_LAT=3 instance.
// Counter checks are compiled in when ARB_PERF_CNT_EN is defined.
module tb_imem_dmem_arbiter;
   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   int   total  = 0;
   int   bad    = 0;

   always #5 clk_in = ~clk_in;

   imem_dmem_arbiter_if #(.ADDR_W(32)) bus ();
   imem_dmem_arbiter_if #(.ADDR_W(32)) bus3 ();

   imem_dmem_arbiter #(.ADDR_W(32), .MEM_LAT(1), .MAX_DATA_STREAK(4)) u_dut (
      .clk_in(clk_in), .rst_in(rst_in), .bus(bus)
   );
   imem_dmem_arbiter #(.ADDR_W(32), .MEM_LAT(3), .MAX_DATA_STREAK(4)) u_dut3 (
      .clk_in(clk_in), .rst_in(rst_in), .bus(bus3)
   );

   // Memory models: return mem_ret exactly MEM_LAT cycles after the enable cycle, junk otherwise.
   logic [31:0] mem_ret;
   logic [31:0] mem_ret3;
   logic [32:0] p1 = '0;
   logic [32:0] p3 [3] = '{default: '0};
   always @(posedge clk_in) begin
      p1    <= {bus.mem_en_out, mem_ret};
      p3[0] <= {bus3.mem_en_out, mem_ret3};
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign bus.mem_rdata_in  = p1[32] ? p1[31:0] : 32'hBADBAD00;
   assign bus3.mem_rdata_in = p3[2][32] ? p3[2][31:0] : 32'hBADBAD03;

   typedef struct {
      logic        dm;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic [31:0] wdata;
      logic [31:0] ret;
      logic        exp_we;
      logic [3:0]  exp_mask;
      logic [31:0] exp_wdata;
      logic [31:0] exp_if_data;
      logic [31:0] exp_dm_rdata;
   } vec_t;

   vec_t vecs [5];

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic run_txn(input int k, input vec_t v);
      mem_ret = v.ret;
      if (v.dm) begin
         bus.dm_req_in     = 1'b1;
         bus.dm_wr_in      = v.wr;
         bus.dm_addr_in    = v.addr;
         bus.dm_wr_mask_in = v.mask;
         bus.dm_wdata_in   = v.wdata;
      end else begin
         bus.if_req_in  = 1'b1;
         bus.if_addr_in = v.addr;
      end
      step(); // ISSUE
      chk($sformatf("v%0d en", k), 32'(bus.mem_en_out), 32'd1);
      chk($sformatf("v%0d addr", k), bus.mem_addr_out, v.addr);
      chk($sformatf("v%0d we", k), 32'(bus.mem_we_out), 32'(v.exp_we));
      chk($sformatf("v%0d busy1", k), 32'(bus.busy_out), 32'd1);
      if (!(v.dm && !v.wr)) begin
         chk($sformatf("v%0d mask", k), 32'(bus.mem_mask_out), 32'(v.exp_mask));
         chk($sformatf("v%0d wdata", k), bus.mem_wdata_out, v.exp_wdata);
      end
      bus.if_req_in   = 1'b0;
      bus.dm_req_in   = 1'b0;
      bus.if_addr_in  = 32'hDEAD0000;
      bus.dm_addr_in  = 32'hDEAD0004;
      bus.dm_wdata_in = 32'h0;
      step(); // WAIT
      chk($sformatf("v%0d en_off", k), 32'(bus.mem_en_out), 32'd0);
      chk($sformatf("v%0d early_v", k), 32'({bus.if_valid_out, bus.dm_valid_out}), 32'd0);
      step(); // RESP
      chk($sformatf("v%0d if_v", k), 32'(bus.if_valid_out), 32'(!v.dm));
      chk($sformatf("v%0d dm_v", k), 32'(bus.dm_valid_out), 32'(v.dm));
      chk($sformatf("v%0d if_data", k), bus.if_data_out, v.exp_if_data);
      chk($sformatf("v%0d dm_rdata", k), bus.dm_rdata_out, v.exp_dm_rdata);
      chk($sformatf("v%0d busy3", k), 32'(bus.busy_out), 32'd1);
      step(); // IDLE
      chk($sformatf("v%0d v_off", k), 32'({bus.if_valid_out, bus.dm_valid_out}), 32'd0);
      chk($sformatf("v%0d idle", k), 32'(bus.busy_out), 32'd0);
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      step(2);
      rst_in = 1'b0;
   endtask

   logic       exp_dm [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
   logic       got;

   initial begin
      //        dm wr addr          mask     wdata         ret           we mask     wdata         if_data       dm_rdata
      vecs[0] = '{0, 0, 32'h100,      4'hF, 32'hFFFFFFFF, 32'h00500093, 0, 4'b0000, 32'h0,        32'h00500093, 32'h0};
      vecs[1] = '{1, 1, 32'h2004,     4'h3, 32'hDEADBEEF, 32'h11111111, 1, 4'b0011, 32'hDEADBEEF, 32'h00500093, 32'h0};
      vecs[2] = '{1, 0, 32'h2008,     4'hF, 32'h0,        32'hA5A5A5A5, 0, 4'b1111, 32'h0,        32'h00500093, 32'hA5A5A5A5};
      vecs[3] = '{1, 1, 32'h2003,     4'h0, 32'h12345678, 32'h22222222, 1, 4'b0000, 32'h12345678, 32'h00500093, 32'hA5A5A5A5};
      vecs[4] = '{0, 0, 32'hFFFFFFFC, 4'h0, 32'h0,        32'h00000013, 0, 4'b0000, 32'h0,        32'h00000013, 32'hA5A5A5A5};

      bus.if_req_in = 0; bus.if_addr_in = 0;
      bus.dm_req_in = 0; bus.dm_wr_in = 0; bus.dm_addr_in = 0;
      bus.dm_wr_mask_in = 0; bus.dm_wdata_in = 0;
      bus3.if_req_in = 0; bus3.if_addr_in = 0;
      bus3.dm_req_in = 0; bus3.dm_wr_in = 0; bus3.dm_addr_in = 0;
      bus3.dm_wr_mask_in = 0; bus3.dm_wdata_in = 0;
      mem_ret = 0; mem_ret3 = 0;
      do_reset();

      chk("rst busy", 32'(bus.busy_out), 32'd0);
      chk("rst mem", 32'({bus.mem_en_out, bus.mem_we_out, bus.mem_mask_out}), 32'd0);
      chk("rst addr", bus.mem_addr_out, 32'd0);
      chk("rst valid", 32'({bus.if_valid_out, bus.dm_valid_out}), 32'd0);
      chk("rst data", bus.if_data_out | bus.dm_rdata_out, 32'd0);
      chk("rst3 busy", 32'(bus3.busy_out), 32'd0);

      for (int i = 0; i < 5; i++) run_txn(i, vecs[i]);

      // Reset during WAIT of a fetch: outputs clear at once, no late valid.
      mem_ret = 32'h77777777;
      bus.if_req_in = 1'b1; bus.if_addr_in = 32'h400;
      step();
      bus.if_req_in = 1'b0;
      step();
      #2 rst_in = 1'b1;
      #1;
      chk("arst busy", 32'(bus.busy_out), 32'd0);
      chk("arst if_data", bus.if_data_out, 32'd0);
      chk("arst dm_rdata", bus.dm_rdata_out, 32'd0);
      chk("arst mem", 32'({bus.mem_en_out, bus.mem_we_out, bus.mem_mask_out}), 32'd0);
      chk("arst maddr", bus.mem_addr_out, 32'd0);
      step();
      rst_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst if_v", 32'({bus.if_valid_out, bus.busy_out}), 32'd0);
      end
      run_txn(5, vecs[0]);

      // Both requesters held high: streak limit forces every fifth grant to IF.
      do_reset();
      bus.if_req_in = 1'b1; bus.if_addr_in = 32'h100;
      bus.dm_req_in = 1'b1; bus.dm_wr_in = 1'b0; bus.dm_addr_in = 32'h200;
      for (int g = 0; g < 10; g++) begin
         got = 1'b0;
         for (int t = 0; t < 8; t++) begin
            step();
            if (bus.mem_en_out) begin
               got = 1'b1;
               break;
            end
         end
         if (!got) chk($sformatf("grant%0d timeout", g), 32'd0, 32'd1);
         else chk($sformatf("grant%0d dm", g), 32'(bus.mem_addr_out == 32'h200), 32'(exp_dm[g]));
      end
      bus.if_req_in = 1'b0;
      bus.dm_req_in = 1'b0;
      step(4);
      chk("order idle", 32'(bus.busy_out), 32'd0);
`ifdef ARB_PERF_CNT_EN
      chk("cnt if", bus.if_grant_cnt_out, 32'd2);
      chk("cnt dm", bus.dm_grant_cnt_out, 32'd8);
      chk("cnt conflict", bus.conflict_cnt_out, 32'd10);
`endif

      // MEM_LAT=3 data read: valid exactly at c0+5.
      mem_ret3 = 32'h12345678;
      bus3.dm_req_in = 1'b1; bus3.dm_wr_in = 1'b0; bus3.dm_addr_in = 32'h3000;
      step();
      chk("lat3 en", 32'(bus3.mem_en_out), 32'd1);
      chk("lat3 addr", bus3.mem_addr_out, 32'h3000);
      bus3.dm_req_in = 1'b0;
      for (int c = 2; c <= 4; c++) begin
         step();
         chk($sformatf("lat3 c%0d v", c), 32'(bus3.dm_valid_out), 32'd0);
      end
      step();
      chk("lat3 c5 v", 32'(bus3.dm_valid_out), 32'd1);
      chk("lat3 data", bus3.dm_rdata_out, 32'h12345678);
      step();
      chk("lat3 c6 v", 32'({bus3.dm_valid_out, bus3.busy_out}), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
